// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic mode scheduler.
// The mode order matches the downstream mode decoder and light-output mux.
package traffic_pkg;

  typedef enum logic [1:0] {
    MODE_DAY   = 2'd0,
    MODE_NIGHT = 2'd1,
    MODE_PED   = 2'd2,
    MODE_EMG   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Fixed request priority: emergency over pedestrian over time of day.
  function automatic mode_e pick_mode(input logic emg, input logic ped, input logic night);
    if (emg) begin
      return MODE_EMG;
    end else if (ped) begin
      return MODE_PED;
    end else if (night) begin
      return MODE_NIGHT;
    end else begin
      return MODE_DAY;
    end
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter. done_o flags the enabled edge on which the count reaches zero.
module interval_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  // A load takes priority over counting; the count parks at zero once it has expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else if (load_i) begin
      count_q <= value_i;
    end else if (en_i && (count_q != {CNT_W{1'b0}})) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_o = en_i && !load_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_mode_scheduler.sv
// Intersection mode sequencer: arbitrates emergency, pedestrian and time-of-day requests,
// enforces a minimum dwell per mode and an all-red clearance between any two modes.
module traffic_mode_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_DWELL    = 8,
  parameter int CLEAR_CYCLES = 4,
  parameter int PED_CYCLES   = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timeSignal,
  input  logic       pedSignal,
  input  logic       emgSignal,
  input  logic [7:0] emgLane,
  output logic [1:0] trafficMode,
  output logic       clearing,
  output logic       pedAck,
  output logic [7:0] emgLaneOut
);

  state_e           state_q;
  mode_e            mode_q;
  logic             clearing_q;
  logic             ped_ack_q;
  logic [7:0]       emg_lane_q;
  logic             ped_pending_q;
  logic [CNT_W-1:0] dwell_q;

  logic  ped_serving;
  logic  ped_done;
  logic  ped_load;
  logic  ped_req;
  logic  clr_done;
  logic  dwell_met;
  logic  switch_req;
  mode_e desired;

  // A pulse seen this edge counts immediately, and a request retired this edge no longer counts,
  // so a served pedestrian phase hands straight over to clearance without an extra PED cycle.
  assign ped_serving = (state_q == ST_RUN) && (mode_q == MODE_PED);
  assign ped_req     = (ped_pending_q || (pedSignal && (mode_q != MODE_PED))) && !ped_done;
  assign desired     = pick_mode(emgSignal, ped_req, timeSignal);
  assign dwell_met   = (dwell_q == CNT_W'(MIN_DWELL));
  assign switch_req  = (state_q == ST_RUN) && (desired != mode_q) &&
                       (dwell_met || (desired == MODE_EMG));
  assign ped_load    = clr_done && (desired == MODE_PED);

  interval_timer #(.CNT_W(CNT_W)) u_clear_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (switch_req),
    .value_i (CNT_W'(CLEAR_CYCLES)),
    .en_i    (state_q == ST_CLEAR),
    .done_o  (clr_done)
  );

  interval_timer #(.CNT_W(CNT_W)) u_ped_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ped_load),
    .value_i (CNT_W'(PED_CYCLES)),
    .en_i    (ped_serving),
    .done_o  (ped_done)
  );

  // Mode FSM with dwell counter, pending pedestrian latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      mode_q        <= MODE_DAY;
      clearing_q    <= 1'b0;
      ped_ack_q     <= 1'b0;
      emg_lane_q    <= 8'h00;
      ped_pending_q <= 1'b0;
      dwell_q       <= {CNT_W{1'b0}};
    end else begin
      ped_ack_q <= ped_done;
      if (ped_done) begin
        ped_pending_q <= 1'b0;
      end else if (pedSignal && (mode_q != MODE_PED)) begin
        ped_pending_q <= 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (switch_req) begin
            state_q    <= ST_CLEAR;
            clearing_q <= 1'b1;
            dwell_q    <= {CNT_W{1'b0}};
            if (mode_q == MODE_EMG) begin
              emg_lane_q <= 8'h00;
            end
          end else if (!dwell_met) begin
            dwell_q <= dwell_q + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          // The target is whatever is desired at expiry; retargeting never stretches the clearance.
          if (clr_done) begin
            state_q    <= ST_RUN;
            clearing_q <= 1'b0;
            mode_q     <= desired;
            dwell_q    <= {CNT_W{1'b0}};
            emg_lane_q <= (desired == MODE_EMG) ? emgLane : 8'h00;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          clearing_q <= 1'b0;
        end
      endcase
    end
  end

  assign trafficMode = mode_q;
  assign clearing    = clearing_q;
  assign pedAck      = ped_ack_q;
  assign emgLaneOut  = emg_lane_q;

endmodule

// File: tb/tb_traffic_mode_scheduler.sv
// Directed table-driven bench for traffic_mode_scheduler (default parameters).
module tb_traffic_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timeSignal = 1'b0;
  logic       pedSignal = 1'b0;
  logic       emgSignal = 1'b0;
  logic [7:0] emgLane = 8'h00;
  logic [1:0] trafficMode;
  logic       clearing;
  logic       pedAck;
  logic [7:0] emgLaneOut;

  int checks = 0;
  int failures = 0;

  traffic_mode_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .timeSignal  (timeSignal),
    .pedSignal   (pedSignal),
    .emgSignal   (emgSignal),
    .emgLane     (emgLane),
    .trafficMode (trafficMode),
    .clearing    (clearing),
    .pedAck      (pedAck),
    .emgLaneOut  (emgLaneOut)
  );

  always #5 clk = ~clk;

  // One record: inputs held for n edges, expected outputs after each of those edges.
  typedef struct {
    int         n;
    logic       t;
    logic       p;
    logic       e;
    logic [7:0] lane;
    logic [1:0] mode;
    logic       clr;
    logic       ack;
    logic [7:0] elo;
  } vec_t;

  vec_t tbl[$];
  int   row_id = 0;

  task automatic add(input int n, input logic t, input logic p, input logic e, input logic [7:0] lane,
                     input logic [1:0] mode, input logic clr, input logic ack, input logic [7:0] elo);
    vec_t v;
    v.n = n; v.t = t; v.p = p; v.e = e; v.lane = lane;
    v.mode = mode; v.clr = clr; v.ack = ack; v.elo = elo;
    tbl.push_back(v);
  endtask

  task automatic check_now(input string name, input logic [1:0] mode, input logic clr,
                           input logic ack, input logic [7:0] elo);
    checks++;
    if (trafficMode !== mode || clearing !== clr || pedAck !== ack || emgLaneOut !== elo) begin
      failures++;
      $display("FAIL %s: got mode=%0d clearing=%b pedAck=%b emgLaneOut=%h, want mode=%0d clearing=%b pedAck=%b emgLaneOut=%h",
               name, trafficMode, clearing, pedAck, emgLaneOut, mode, clr, ack, elo);
    end
  endtask

  task automatic run_row(input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      timeSignal = v.t;
      pedSignal  = v.p;
      emgSignal  = v.e;
      emgLane    = v.lane;
      @(posedge clk);
      #1;
      check_now($sformatf("row%0d_cyc%0d", row_id, c), v.mode, v.clr, v.ack, v.elo);
    end
    row_id++;
  endtask

  task automatic async_reset_check(input string name);
    #1 rst = 1'b1;
    #1 check_now(name, 2'd0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 check_now({name, "_held"}, 2'd0, 1'b0, 1'b0, 8'h00);
    timeSignal = 1'b0; pedSignal = 1'b0; emgSignal = 1'b0; emgLane = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: idle from reset
    add(20, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    // Test 2: single pedestrian pulse, full service, return to DAY
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(16, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b1, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 8'h00);
    add(10, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    // Test 3: emergency preempts PED at cycle 2, lane held, PED re-served in full
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(2,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(4,  1'b0, 1'b0, 1'b1, 8'h24, 2'd2, 1'b1, 1'b0, 8'h00);
    add(6,  1'b0, 1'b0, 1'b1, 8'h24, 2'd3, 1'b0, 1'b0, 8'h24);
    add(6,  1'b0, 1'b0, 1'b1, 8'h81, 2'd3, 1'b0, 1'b0, 8'h24);
    add(4,  1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0, 8'h00);
    add(16, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b1, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 8'h00);
    add(10, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    // Simultaneous emg+ped: EMG wins, early drop waits for dwell, then PED served
    add(1,  1'b0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 8'h00);
    add(5,  1'b0, 1'b0, 1'b1, 8'h11, 2'd3, 1'b0, 1'b0, 8'h11);
    add(4,  1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 8'h11);
    add(4,  1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0, 8'h00);
    add(16, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b1, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 8'h00);
    add(10, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    // Test 5: repeated pedestrian pulses give one service and one ack
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(2,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(12, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 1'b1, 1'b1, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    // Test 4: night request at dwell 3 waits for dwell 8; toggling back during CLEAR resumes DAY
    add(6,  1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    add(2,  1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(2,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(1,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    add(8,  1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    add(4,  1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00);
    add(9,  1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 8'h00);

    rst = 1'b1;
    @(posedge clk);
    #1 check_now("reset_state", 2'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_row(tbl[i]);

    // Test 6: asynchronous reset mid-CLEAR towards PED discards the pending request
    tbl.delete();
    add(1,  1'b1, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 8'h00);
    add(1,  1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 8'h00);
    foreach (tbl[i]) run_row(tbl[i]);
    async_reset_check("async_rst_mid_clear");

    tbl.delete();
    add(30, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    add(1,  1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 1'b1, 1'b0, 8'h00);
    add(3,  1'b0, 1'b0, 1'b1, 8'h5A, 2'd3, 1'b0, 1'b0, 8'h5A);
    foreach (tbl[i]) run_row(tbl[i]);
    async_reset_check("async_rst_in_emg");

    tbl.delete();
    add(5,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    foreach (tbl[i]) run_row(tbl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
